// File: rtl/cook_timer_if.sv
// Keypad, magnetron feedback and display bundle for the cook timer.
// The controller side drives keys and mag_on; the timer drives the time and the status flags.
interface cook_timer_if;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       clearn;
  logic       mag_on;
  logic       timerdone;
  logic       running;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;

  modport master (
    output key_valid, key_digit, clearn, mag_on,
    input  timerdone, running, min_tens, min_ones, sec_tens, sec_ones
  );

  modport slave (
    input  key_valid, key_digit, clearn, mag_on,
    output timerdone, running, min_tens, min_ones, sec_tens, sec_ones
  );
endinterface

// File: rtl/cook_timer.sv
// MM:SS BCD countdown timer: keypad entry, one-second prescaler gated by mag_on,
// and status flags decoded from the registered state.
module cook_timer #(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic        clk,
  input  logic        reset,
  cook_timer_if.slave tif
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] LAST_TICK = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [2:0] {IDLE, SET, RUN, PAUSE, DONE} state_t;

  state_t        state_reg;
  logic [PW-1:0] prescale_reg;
  logic [3:0]    min_tens_reg, min_ones_reg, sec_tens_reg, sec_ones_reg;

  logic [3:0] dec_mt, dec_mo, dec_st, dec_so;
  logic       dec_zero;
  logic       key_ok;
  logic       entry_nonzero;

  // BCD decrement with borrow across all four digits.
  always_comb begin
    dec_mt = min_tens_reg;
    dec_mo = min_ones_reg;
    dec_st = sec_tens_reg;
    dec_so = sec_ones_reg;
    if (sec_ones_reg != 4'd0) begin
      dec_so = sec_ones_reg - 4'd1;
    end else begin
      dec_so = 4'd9;
      if (sec_tens_reg != 4'd0) begin
        dec_st = sec_tens_reg - 4'd1;
      end else begin
        dec_st = 4'd5;
        if (min_ones_reg != 4'd0) begin
          dec_mo = min_ones_reg - 4'd1;
        end else begin
          dec_mo = 4'd9;
          dec_mt = min_tens_reg - 4'd1;
        end
      end
    end
    dec_zero = ({dec_mt, dec_mo, dec_st, dec_so} == 16'h0000);
  end

  assign key_ok = tif.key_valid && (tif.key_digit <= 4'd9) && !tif.mag_on;

  // After a DONE entry the old digits are all zero, so only the new key matters.
  assign entry_nonzero = (state_reg == DONE) ? (tif.key_digit != 4'd0)
                       : ({min_ones_reg, sec_tens_reg, sec_ones_reg, tif.key_digit} != 16'h0000);

  always_ff @(posedge clk) begin
    if (reset || !tif.clearn) begin
      state_reg    <= IDLE;
      prescale_reg <= '0;
      min_tens_reg <= 4'd0;
      min_ones_reg <= 4'd0;
      sec_tens_reg <= 4'd0;
      sec_ones_reg <= 4'd0;
    end else begin
      case (state_reg)
        IDLE, SET, DONE: begin
          if (key_ok) begin
            if (state_reg == DONE) begin
              min_tens_reg <= 4'd0;
              min_ones_reg <= 4'd0;
              sec_tens_reg <= 4'd0;
            end else begin
              min_tens_reg <= min_ones_reg;
              min_ones_reg <= sec_tens_reg;
              sec_tens_reg <= sec_ones_reg;
            end
            sec_ones_reg <= tif.key_digit;
            state_reg    <= entry_nonzero ? SET : IDLE;
          end else if (state_reg == SET && tif.mag_on) begin
            state_reg    <= RUN;
            prescale_reg <= '0;
          end
        end
        RUN: begin
          if (!tif.mag_on) begin
            state_reg <= PAUSE;
          end else if (prescale_reg == LAST_TICK) begin
            prescale_reg <= '0;
            min_tens_reg <= dec_mt;
            min_ones_reg <= dec_mo;
            sec_tens_reg <= dec_st;
            sec_ones_reg <= dec_so;
            if (dec_zero) begin
              state_reg <= DONE;
            end
          end else begin
            prescale_reg <= prescale_reg + PW'(1);
          end
        end
        PAUSE: begin
          if (tif.mag_on) begin
            state_reg <= RUN;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign tif.timerdone = (state_reg == IDLE) || (state_reg == DONE);
  assign tif.running   = (state_reg == RUN);
  assign tif.min_tens  = min_tens_reg;
  assign tif.min_ones  = min_ones_reg;
  assign tif.sec_tens  = sec_tens_reg;
  assign tif.sec_ones  = sec_ones_reg;

endmodule

// File: tb/tb_cook_timer.sv
// Directed bench for cook_timer with a four-cycle second.
module tb_cook_timer;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  cook_timer_if tif ();

  cook_timer #(.TICKS_PER_SEC(4)) dut (
    .clk   (clk),
    .reset (reset),
    .tif   (tif)
  );

  wire [15:0] disp = {tif.min_tens, tif.min_ones, tif.sec_tens, tif.sec_ones};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are stable and inputs may be changed on return.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    tif.key_valid = 1'b1;
    tif.key_digit = d;
    step();
    tif.key_valid = 1'b0;
    tif.key_digit = 4'd0;
  endtask

  task automatic do_clear();
    tif.clearn = 1'b0;
    step();
    tif.clearn = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    checks++;
    if (disp !== 16'h0000) begin errors++; $display("FAIL reset_digits got %h want 0000", disp); end
    checks++;
    if (tif.timerdone !== 1'b1 || tif.running !== 1'b0) begin
      errors++; $display("FAIL reset_flags got td=%b run=%b want td=1 run=0", tif.timerdone, tif.running);
    end
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
    checks++;
    if (disp !== 16'h2345) begin errors++; $display("FAIL key_shift got %h want 2345", disp); end
    checks++;
    if (tif.timerdone !== 1'b0 || tif.running !== 1'b0) begin
      errors++; $display("FAIL set_flags got td=%b run=%b want td=0 run=0", tif.timerdone, tif.running);
    end
    $display("test_reset done");
  endtask

  task automatic test_countdown();
    do_clear();
    press(4'd0); press(4'd0); press(4'd0); press(4'd2);
    tif.mag_on = 1'b1;
    step();
    checks++;
    if (tif.running !== 1'b1 || disp !== 16'h0002) begin
      errors++; $display("FAIL run_entry got run=%b disp=%h want run=1 disp=0002", tif.running, disp);
    end
    step(); step(); step();
    checks++;
    if (disp !== 16'h0002) begin errors++; $display("FAIL pre_tick got %h want 0002", disp); end
    step();
    checks++;
    if (disp !== 16'h0001) begin errors++; $display("FAIL first_tick got %h want 0001", disp); end
    step(); step(); step();
    checks++;
    if (disp !== 16'h0001 || tif.timerdone !== 1'b0) begin
      errors++; $display("FAIL pre_final got disp=%h td=%b want 0001 td=0", disp, tif.timerdone);
    end
    step();
    checks++;
    if (disp !== 16'h0000) begin errors++; $display("FAIL final_tick got %h want 0000", disp); end
    checks++;
    if (tif.timerdone !== 1'b1 || tif.running !== 1'b0) begin
      errors++; $display("FAIL done_flags got td=%b run=%b want td=1 run=0", tif.timerdone, tif.running);
    end
    $display("test_countdown done");
  endtask

  task automatic test_done_entry();
    tif.mag_on = 1'b0;
    step();
    press(4'd7);
    checks++;
    if (disp !== 16'h0007 || tif.timerdone !== 1'b0 || tif.running !== 1'b0) begin
      errors++; $display("FAIL done_entry got disp=%h td=%b run=%b want 0007 td=0 run=0",
                         disp, tif.timerdone, tif.running);
    end
    $display("test_done_entry done");
  endtask

  task automatic run_one_tick();
    tif.mag_on = 1'b1;
    for (int i = 0; i < 5; i++) step();
    tif.mag_on = 1'b0;
  endtask

  task automatic test_borrow();
    do_clear();
    press(4'd0); press(4'd1); press(4'd0); press(4'd0);
    run_one_tick();
    checks++;
    if (disp !== 16'h0059) begin errors++; $display("FAIL borrow_min got %h want 0059", disp); end
    do_clear();
    press(4'd0); press(4'd0); press(4'd9); press(4'd0);
    run_one_tick();
    checks++;
    if (disp !== 16'h0089) begin errors++; $display("FAIL big_tens got %h want 0089", disp); end
    do_clear();
    press(4'd1); press(4'd0); press(4'd0); press(4'd0);
    run_one_tick();
    checks++;
    if (disp !== 16'h0959) begin errors++; $display("FAIL borrow_tens got %h want 0959", disp); end
    $display("test_borrow done");
  endtask

  task automatic test_pause();
    do_clear();
    press(4'd3);
    tif.mag_on = 1'b1;
    step();
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (disp !== 16'h0002) begin errors++; $display("FAIL pause_pre got %h want 0002", disp); end
    tif.mag_on = 1'b0;
    step();
    checks++;
    if (tif.running !== 1'b0 || tif.timerdone !== 1'b0) begin
      errors++; $display("FAIL pause_flags got run=%b td=%b want run=0 td=0", tif.running, tif.timerdone);
    end
    for (int i = 0; i < 4; i++) step();
    press(4'd5);
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (disp !== 16'h0002) begin errors++; $display("FAIL pause_hold got %h want 0002", disp); end
    tif.mag_on = 1'b1;
    step();
    checks++;
    if (tif.running !== 1'b1) begin errors++; $display("FAIL resume got run=%b want 1", tif.running); end
    step();
    checks++;
    if (disp !== 16'h0002) begin errors++; $display("FAIL resume_early got %h want 0002", disp); end
    step();
    checks++;
    if (disp !== 16'h0001) begin errors++; $display("FAIL resume_tick got %h want 0001", disp); end
    tif.mag_on = 1'b0;
    step();
    $display("test_pause done");
  endtask

  task automatic test_clear();
    do_clear();
    press(4'd5);
    tif.mag_on = 1'b1;
    step();
    step(); step(); step();
    tif.clearn    = 1'b0;
    tif.key_valid = 1'b1;
    tif.key_digit = 4'd3;
    step();
    tif.clearn    = 1'b1;
    tif.key_valid = 1'b0;
    checks++;
    if (disp !== 16'h0000 || tif.timerdone !== 1'b1 || tif.running !== 1'b0) begin
      errors++; $display("FAIL clear_prio got disp=%h td=%b run=%b want 0000 td=1 run=0",
                         disp, tif.timerdone, tif.running);
    end
    press(4'd4);
    step(); step();
    checks++;
    if (disp !== 16'h0000 || tif.timerdone !== 1'b1 || tif.running !== 1'b0) begin
      errors++; $display("FAIL idle_mag got disp=%h td=%b run=%b want 0000 td=1 run=0",
                         disp, tif.timerdone, tif.running);
    end
    tif.mag_on = 1'b0;
    step();
    press(4'd5);
    press(4'd12);
    checks++;
    if (disp !== 16'h0005) begin errors++; $display("FAIL bad_key got %h want 0005", disp); end
    $display("test_clear done");
  endtask

  task automatic test_back_to_back();
    do_clear();
    press(4'd4);
    tif.key_valid = 1'b1;
    tif.key_digit = 4'd8;
    tif.mag_on    = 1'b1;
    step();
    tif.key_valid = 1'b0;
    checks++;
    if (disp !== 16'h0004 || tif.running !== 1'b1) begin
      errors++; $display("FAIL key_with_start got disp=%h run=%b want 0004 run=1", disp, tif.running);
    end
    tif.mag_on = 1'b0;
    step();
    $display("test_back_to_back done");
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    tif.key_valid = 1'b0;
    tif.key_digit = 4'd0;
    tif.clearn    = 1'b1;
    tif.mag_on    = 1'b0;
    test_reset();
    test_countdown();
    test_done_entry();
    test_borrow();
    test_pause();
    test_clear();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
